// File: rtl/quad_pkg.sv
// Shared state constants, direction type and Gray-code step decoder for the
// quadrature decoder channels.
package quad_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;

  typedef enum logic {
    CCW = 1'b0,
    CW  = 1'b1
  } dir_t;

  typedef struct packed {
    logic valid;
    logic illegal;
    dir_t dir;
  } step_t;

  // States are {B,A}; an unchanged state decodes as neither valid nor illegal.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s.valid   = 1'b0;
    s.illegal = 1'b0;
    s.dir     = CCW;
    case ({prev, cur})
      {ST_11, ST_01}, {ST_01, ST_00}, {ST_00, ST_10}, {ST_10, ST_11}: begin
        s.valid = 1'b1;
        s.dir   = CW;
      end
      {ST_11, ST_10}, {ST_10, ST_00}, {ST_00, ST_01}, {ST_01, ST_11}: begin
        s.valid = 1'b1;
      end
      {ST_00, ST_11}, {ST_11, ST_00}, {ST_01, ST_10}, {ST_10, ST_01}: begin
        s.illegal = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: synchroniser, stability filter, step decode,
// step accumulator and wrapping/saturating position counter.
module quad_channel
  import quad_pkg::*;
#(
  parameter int FILTER_LEN      = 4,
  parameter int STEPS_PER_EVENT = 1,
  parameter int CNT_W           = 8,
  parameter int WRAP            = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rota,
  input  logic             rotb,
  input  logic             clear,
  output logic             rotateEvent,
  output logic             direction,
  output logic             err,
  output logic [CNT_W-1:0] position
);

  localparam int ACC_W = 4;
  localparam logic [7:0] FLEN = 8'(FILTER_LEN);
  localparam logic signed [ACC_W-1:0] SPE = ACC_W'(STEPS_PER_EVENT);

  logic [1:0] s1_p0, s2_p1, s2_prev_p1, filt_p2, filt_prev_p2;
  logic [7:0] stab_cnt_p1, stab_cnt_nxt;
  logic       load_p1;
  logic signed [ACC_W-1:0] acc_p3, acc_nxt, acc_sum, stp;
  logic [CNT_W-1:0] pos_nxt;
  logic       ev_nxt, err_nxt, dir_nxt;
  step_t      step;

  function automatic logic [CNT_W-1:0] step_pos(input logic [CNT_W-1:0] p, input logic up);
    if (up) begin
      if (WRAP == 0 && p == {CNT_W{1'b1}}) return p;
      return p + CNT_W'(1);
    end
    if (WRAP == 0 && p == {CNT_W{1'b0}}) return p;
    return p - CNT_W'(1);
  endfunction

  // ---- stage p1: stability counter over synchronised level ----
  always_comb begin
    stab_cnt_nxt = '0;
    load_p1      = 1'b0;
    if (s2_p1 == filt_p2)         stab_cnt_nxt = '0;
    else if (s2_p1 != s2_prev_p1) stab_cnt_nxt = 8'd1;
    else                          stab_cnt_nxt = stab_cnt_p1 + 8'd1;
    if (stab_cnt_nxt == FLEN) begin
      load_p1      = 1'b1;
      stab_cnt_nxt = '0;
    end
  end

  // ---- stage p3: decode, accumulate, position ----
  always_comb begin
    step    = decode_step(filt_prev_p2, filt_p2);
    acc_nxt = acc_p3;
    acc_sum = acc_p3;
    stp     = (step.dir == CW) ? 4'sd1 : -4'sd1;
    ev_nxt  = 1'b0;
    err_nxt = 1'b0;
    dir_nxt = direction;
    pos_nxt = position;
    if (step.illegal) begin
      err_nxt = 1'b1;
      acc_nxt = '0;
    end else if (step.valid) begin
      // Reversal restarts the count so a jittering detent cannot accumulate.
      if (acc_p3 == 4'sd0 || acc_p3[ACC_W-1] == stp[ACC_W-1]) acc_sum = acc_p3 + stp;
      else                                                  acc_sum = stp;
      if (acc_sum == SPE || acc_sum == -SPE) begin
        ev_nxt  = 1'b1;
        dir_nxt = step.dir;
        acc_nxt = '0;
        pos_nxt = step_pos(position, step.dir == CW);
      end else begin
        acc_nxt = acc_sum;
      end
    end
    if (clear) begin
      acc_nxt = '0;
      pos_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_p0        <= {rotb, rota};
      s2_p1        <= {rotb, rota};
      s2_prev_p1   <= {rotb, rota};
      filt_p2      <= {rotb, rota};
      filt_prev_p2 <= {rotb, rota};
      stab_cnt_p1  <= '0;
      acc_p3       <= '0;
      rotateEvent  <= 1'b0;
      err          <= 1'b0;
      direction    <= 1'b0;
      position     <= '0;
    end else begin
      s1_p0        <= {rotb, rota};
      s2_p1        <= s1_p0;
      s2_prev_p1   <= s2_p1;
      stab_cnt_p1  <= stab_cnt_nxt;
      if (load_p1) filt_p2 <= s2_p1;
      filt_prev_p2 <= filt_p2;
      acc_p3       <= acc_nxt;
      rotateEvent  <= ev_nxt;
      err          <= err_nxt;
      direction    <= dir_nxt;
      position     <= pos_nxt;
    end
  end

endmodule

// File: rtl/quad_decoder_multi.sv
// Multi-channel quadrature decoder: independent quad_channel instances with
// per-channel port slicing.
module quad_decoder_multi
  import quad_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int FILTER_LEN      = 4,
  parameter int STEPS_PER_EVENT = 1,
  parameter int CNT_W           = 8,
  parameter int WRAP            = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       rota,
  input  logic [CHANNELS-1:0]       rotb,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS-1:0]       rotateEvent,
  output logic [CHANNELS-1:0]       direction,
  output logic [CHANNELS-1:0]       err,
  output logic [CHANNELS*CNT_W-1:0] position
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    quad_channel #(
      .FILTER_LEN     (FILTER_LEN),
      .STEPS_PER_EVENT(STEPS_PER_EVENT),
      .CNT_W          (CNT_W),
      .WRAP           (WRAP)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .rota       (rota[i]),
      .rotb       (rotb[i]),
      .clear      (clear[i]),
      .rotateEvent(rotateEvent[i]),
      .direction  (direction[i]),
      .err        (err[i]),
      .position   (position[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_quad_decoder_multi.sv
// Scoreboard bench for quad_decoder_multi: a default instance (A) and a
// four-steps-per-event saturating instance (B).
module tb_quad_decoder_multi;

  localparam int FL  = 4;
  localparam int LAT = FL + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  a_rota = 2'b11, a_rotb = 2'b11, a_clear = 2'b00;
  logic [1:0]  b_rota = 2'b11, b_rotb = 2'b11, b_clear = 2'b00;
  logic [1:0]  a_ev, a_dir, a_err, b_ev, b_dir, b_err;
  logic [15:0] a_pos, b_pos;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int unsigned cyc;
    bit          err;
    bit          dir;
    int          pos;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];

  quad_decoder_multi #(.CHANNELS(2), .FILTER_LEN(FL), .STEPS_PER_EVENT(1),
                       .CNT_W(8), .WRAP(1)) dut_a (
    .clk(clk), .reset(reset), .rota(a_rota), .rotb(a_rotb), .clear(a_clear),
    .rotateEvent(a_ev), .direction(a_dir), .err(a_err), .position(a_pos)
  );

  quad_decoder_multi #(.CHANNELS(2), .FILTER_LEN(FL), .STEPS_PER_EVENT(4),
                       .CNT_W(8), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .rota(b_rota), .rotb(b_rotb), .clear(b_clear),
    .rotateEvent(b_ev), .direction(b_dir), .err(b_err), .position(b_pos)
  );

  task automatic push(input int idx, input int unsigned at, input bit e, input bit d, input int p);
    exp_t x;
    x.cyc = at; x.err = e; x.dir = d; x.pos = p;
    case (idx)
      0: q0.push_back(x);
      1: q1.push_back(x);
      2: q2.push_back(x);
      default: q3.push_back(x);
    endcase
  endtask

  task automatic check_out(input int idx, input logic ev, input logic er, input logic d, input int p);
    exp_t x;
    bit   have;
    have = 1'b1;
    case (idx)
      0: if (q0.size() == 0) have = 1'b0; else x = q0.pop_front();
      1: if (q1.size() == 0) have = 1'b0; else x = q1.pop_front();
      2: if (q2.size() == 0) have = 1'b0; else x = q2.pop_front();
      default: if (q3.size() == 0) have = 1'b0; else x = q3.pop_front();
    endcase
    tests++;
    if (!have) begin
      fails++;
      $display("FAIL unexpected_output idx%0d cyc=%0d got ev=%0b err=%0b pos=%0d required no output",
               idx, cyc, ev, er, p);
    end else if (ev != !x.err || er != x.err || d != x.dir || p != x.pos || cyc != x.cyc) begin
      fails++;
      $display("FAIL output idx%0d got cyc=%0d ev=%0b err=%0b dir=%0b pos=%0d required cyc=%0d err=%0b dir=%0b pos=%0d",
               idx, cyc, ev, er, d, p, x.cyc, x.err, x.dir, x.pos);
    end
  endtask

  task automatic expect_eq(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit isb, input int ch, input logic [1:0] ba);
    if (isb) begin
      b_rotb[ch] = ba[1];
      b_rota[ch] = ba[0];
    end else begin
      a_rotb[ch] = ba[1];
      a_rota[ch] = ba[0];
    end
  endtask

  // Monitor: every output pulse must match the head of its channel queue.
  always @(negedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (a_ev[ch] || a_err[ch]) check_out(ch, a_ev[ch], a_err[ch], a_dir[ch], int'(a_pos[ch*8 +: 8]));
        if (b_ev[ch] || b_err[ch]) check_out(2 + ch, b_ev[ch], b_err[ch], b_dir[ch], int'(b_pos[ch*8 +: 8]));
      end
    end
  end

  initial begin
    tick(3);
    reset = 1'b0;
    expect_eq("reset_pos_a", int'(a_pos), 0);
    expect_eq("reset_dir_a", int'(a_dir), 0);
    expect_eq("reset_pos_b", int'(b_pos), 0);
    tick(100);
    expect_eq("idle_pos_a", int'(a_pos), 0);

    // Four CW steps on A channel 0
    push(0, cyc + LAT, 1'b0, 1'b1, 1); drive(1'b0, 0, 2'b01); tick(10);
    push(0, cyc + LAT, 1'b0, 1'b1, 2); drive(1'b0, 0, 2'b00); tick(10);
    push(0, cyc + LAT, 1'b0, 1'b1, 3); drive(1'b0, 0, 2'b10); tick(10);
    push(0, cyc + LAT, 1'b0, 1'b1, 4); drive(1'b0, 0, 2'b11); tick(10);

    // Two-cycle glitch must be rejected
    drive(1'b0, 0, 2'b01); tick(2);
    drive(1'b0, 0, 2'b11); tick(20);
    expect_eq("glitch_pos0", int'(a_pos[7:0]), 4);

    // Illegal jumps, then a legal CCW step
    push(0, cyc + LAT, 1'b1, 1'b1, 4); drive(1'b0, 0, 2'b00); tick(10);
    push(0, cyc + LAT, 1'b1, 1'b1, 4); drive(1'b0, 0, 2'b11); tick(10);
    push(0, cyc + LAT, 1'b0, 1'b0, 3); drive(1'b0, 0, 2'b10); tick(10);

    // Wrap on A channel 1: down through zero, then back up
    push(1, cyc + LAT, 1'b0, 1'b0, 255); drive(1'b0, 1, 2'b10); tick(10);
    push(1, cyc + LAT, 1'b0, 1'b1, 0);   drive(1'b0, 1, 2'b11); tick(10);
    push(1, cyc + LAT, 1'b0, 1'b1, 1);   drive(1'b0, 1, 2'b01); tick(10);

    // clear coincident with a channel 1 event while channel 0 also steps
    push(1, cyc + LAT, 1'b0, 1'b1, 0);
    push(0, cyc + LAT, 1'b0, 1'b0, 2);
    drive(1'b0, 1, 2'b00);
    drive(1'b0, 0, 2'b00);
    tick(LAT - 1);
    a_clear[1] = 1'b1;
    tick(1);
    a_clear[1] = 1'b0;
    tick(1);
    expect_eq("clear_coinc_pos1", int'(a_pos[15:8]), 0);
    expect_eq("clear_coinc_pos0", int'(a_pos[7:0]), 2);
    tick(10);

    // Standalone clear leaves direction alone
    a_clear[0] = 1'b1;
    tick(1);
    a_clear[0] = 1'b0;
    expect_eq("clear_pos0", int'(a_pos[7:0]), 0);
    expect_eq("clear_dir", int'(a_dir), 2);
    tick(10);

    // B: three CW, then four CCW -> single CCW event saturating at 0
    drive(1'b1, 0, 2'b01); tick(10);
    drive(1'b1, 0, 2'b00); tick(10);
    drive(1'b1, 0, 2'b10); tick(10);
    drive(1'b1, 0, 2'b00); tick(10);
    drive(1'b1, 0, 2'b01); tick(10);
    drive(1'b1, 0, 2'b11); tick(10);
    push(2, cyc + LAT, 1'b0, 1'b0, 0); drive(1'b1, 0, 2'b10); tick(20);
    expect_eq("b_pos0", int'(b_pos[7:0]), 0);
    expect_eq("b_dir0", int'(b_dir[0]), 0);

    tick(20);
    expect_eq("pending_expected", q0.size() + q1.size() + q2.size() + q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
